// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// fir_pkg : widths and coefficient set shared by the 8-tap FIR filter
// Rev 1.0
// ============================================================================
package fir_pkg;

  localparam int N1     = 8;
  localparam int N2     = 16;
  localparam int N3     = 32;
  localparam int NTAPS  = 8;
  localparam int PROD_W = N1 + N2;
  localparam int ACC_W  = N1 + N2 + $clog2(NTAPS);

  // Symmetric low-pass kernel, DC gain 96.
  localparam int COEFFS [0:NTAPS-1] = '{-2, 4, 18, 28, 28, 18, 4, -2};

endpackage
`default_nettype wire

// File: rtl/fir_tap.sv
`default_nettype none
// ============================================================================
// fir_tap : one delay register plus fixed signed coefficient multiplier
// Build option FIR_PIPELINE_EN registers the product. Rev 1.0
// ============================================================================
module fir_tap #(
  parameter int N1    = 8,
  parameter int N2    = 16,
  parameter int COEFF = 0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ENABLE,
  input  logic signed [N2-1:0]    x_in,
  output logic signed [N2-1:0]    x_out,
  output logic signed [N1+N2-1:0] prod_out
);

  localparam int                   PW      = N1 + N2;
  localparam logic signed [N1-1:0] COEFF_W = N1'(COEFF);

  logic signed [N2-1:0] x_d, x_q;
  logic signed [PW-1:0] prod_d;

  // The product uses the sample entering this register, not the stored one.
  always_comb begin
    x_d    = ENABLE ? x_in : x_q;
    prod_d = PW'(x_in) * PW'(COEFF_W);
  end

  always_ff @(posedge CLK) begin
    if (RST) x_q <= '0;
    else     x_q <= x_d;
  end

  assign x_out = x_q;

`ifdef FIR_PIPELINE_EN
  logic signed [PW-1:0] prod_en_d, prod_q;

  always_comb begin
    prod_en_d = ENABLE ? prod_d : prod_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) prod_q <= '0;
    else     prod_q <= prod_en_d;
  end

  assign prod_out = prod_q;
`else
  assign prod_out = prod_d;
`endif

endmodule
`default_nettype wire

// File: rtl/fir_filter.sv
`default_nettype none
// ============================================================================
// fir_filter : 8-tap direct-form fixed-coefficient FIR, full-precision output
// Build option FIR_PIPELINE_EN adds a product register stage. Rev 1.0
// ============================================================================
module fir_filter #(
  parameter int N1 = fir_pkg::N1,
  parameter int N2 = fir_pkg::N2,
  parameter int N3 = fir_pkg::N3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ENABLE,
  input  logic signed [N2-1:0] input_data,
  output logic signed [N3-1:0] output_data,
  output logic signed [N2-1:0] sampleT
);

  import fir_pkg::*;

  localparam int PW = N1 + N2;
  localparam int AW = PW + $clog2(NTAPS);

  logic signed [N2-1:0] tap_in [NTAPS];
  logic signed [N2-1:0] x_q    [NTAPS];
  logic signed [PW-1:0] prod   [NTAPS];
  logic signed [AW-1:0] acc;
  logic signed [N3-1:0] output_data_d, output_data_q;

  generate
    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
      if (k == 0) begin : g_head
        assign tap_in[k] = input_data;
      end else begin : g_chain
        assign tap_in[k] = x_q[k-1];
      end

      fir_tap #(
        .N1    (N1),
        .N2    (N2),
        .COEFF (COEFFS[k])
      ) u_tap (
        .CLK      (CLK),
        .RST      (RST),
        .ENABLE   (ENABLE),
        .x_in     (tap_in[k]),
        .x_out    (x_q[k]),
        .prod_out (prod[k])
      );
    end
  endgenerate

  // Accumulator is wide enough for eight worst-case products, so no overflow.
  always_comb begin
    acc = '0;
    for (int k = 0; k < NTAPS; k++) begin
      acc = acc + AW'(prod[k]);
    end
    output_data_d = ENABLE ? N3'(acc) : output_data_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) output_data_q <= '0;
    else     output_data_q <= output_data_d;
  end

  assign output_data = output_data_q;
  assign sampleT     = x_q[0];

endmodule
`default_nettype wire

// File: tb/tb_fir_filter.sv
`default_nettype none
// ============================================================================
// tb_fir_filter : scoreboard-driven self-checking bench for fir_filter
// Rev 1.0
// ============================================================================
module tb_fir_filter;

  import fir_pkg::*;

`ifdef FIR_PIPELINE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic signed [31:0] out;
    logic signed [15:0] samp;
  } exp_t;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               ENABLE = 1'b0;
  logic signed [15:0] input_data = '0;
  logic signed [31:0] output_data;
  logic signed [15:0] sampleT;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail = 0;

  int   m_hist [0:7];
  int   m_pipe = 0;
  int   m_out = 0;
  int   m_samp = 0;

  fir_filter dut (
    .CLK         (CLK),
    .RST         (RST),
    .ENABLE      (ENABLE),
    .input_data  (input_data),
    .output_data (output_data),
    .sampleT     (sampleT)
  );

  always #5 CLK = ~CLK;

  // Drive one edge, advance the reference model, push its prediction.
  task automatic apply(input logic rst, input logic en, input logic signed [15:0] din);
    int s;
    int d;
    RST = rst;
    ENABLE = en;
    input_data = din;
    @(posedge CLK);
    d = din;
    if (rst) begin
      for (int k = 0; k < 8; k++) m_hist[k] = 0;
      m_pipe = 0;
      m_out  = 0;
      m_samp = 0;
    end else if (en) begin
      s = COEFFS[0] * d;
      for (int k = 1; k < 8; k++) s += COEFFS[k] * m_hist[k-1];
      for (int k = 7; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = d;
      m_samp = d;
      if (LAT == 2) begin
        m_out  = m_pipe;
        m_pipe = s;
      end else begin
        m_out = s;
      end
    end
    sb.push_back('{out: m_out, samp: 16'(m_samp)});
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    apply(1'b1, 1'($urandom_range(0, 1)), 16'($urandom));
    e = sb.pop_front();
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      if (i < 2) apply(1'b1, 1'($urandom_range(0, 1)), 16'($urandom));
      else       apply(1'b0, 1'b1, 16'sd0);
      e = sb.pop_front();
      n_checks++;
      if (output_data !== 32'sd0 || output_data !== e.out) begin
        n_fail++;
        $display("FAIL reset output_data[%0d] got %0d expected 0", i, output_data);
      end
      n_checks++;
      if (sampleT !== 16'sd0 || sampleT !== e.samp) begin
        n_fail++;
        $display("FAIL reset sampleT[%0d] got %0d expected 0", i, sampleT);
      end
    end
  endtask

  task automatic test_impulse();
    exp_t e;
    int   imp [0:8] = '{-2, 4, 18, 28, 28, 18, 4, -2, 0};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b1, (i == 0) ? 16'sd1 : 16'sd0);
      e = sb.pop_front();
      n_checks++;
      if (output_data !== e.out) begin
        n_fail++;
        $display("FAIL impulse output_data[%0d] got %0d expected %0d", i, output_data, e.out);
      end
      n_checks++;
      if (sampleT !== e.samp) begin
        n_fail++;
        $display("FAIL impulse sampleT[%0d] got %0d expected %0d", i, sampleT, e.samp);
      end
      if (i >= LAT - 1 && i - (LAT - 1) <= 8) begin
        n_checks++;
        if (output_data !== 32'(imp[i-(LAT-1)])) begin
          n_fail++;
          $display("FAIL impulse_table[%0d] got %0d expected %0d", i, output_data, imp[i-(LAT-1)]);
        end
      end
    end
  endtask

  task automatic test_step();
    exp_t               e;
    logic signed [15:0] vals [0:2] = '{16'sd100, 16'sd32767, -16'sd32768};
    int                 fin  [0:2] = '{9600, 3145632, -3145728};
    for (int v = 0; v < 3; v++) begin
      do_reset();
      for (int i = 0; i < 12; i++) begin
        apply(1'b0, 1'b1, vals[v]);
        e = sb.pop_front();
        n_checks++;
        if (output_data !== e.out || sampleT !== e.samp) begin
          n_fail++;
          $display("FAIL step%0d[%0d] out/sampleT got %0d/%0d expected %0d/%0d",
                   v, i, output_data, sampleT, e.out, e.samp);
        end
      end
      n_checks++;
      if (output_data !== 32'(fin[v])) begin
        n_fail++;
        $display("FAIL step%0d settled got %0d expected %0d", v, output_data, fin[v]);
      end
    end
  endtask

  task automatic test_neg_impulse();
    exp_t e;
    int   first [0:1] = '{65536, -131072};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b1, (i == 0) ? -16'sd32768 : 16'sd0);
      e = sb.pop_front();
      n_checks++;
      if (output_data !== e.out || sampleT !== e.samp) begin
        n_fail++;
        $display("FAIL neg_impulse[%0d] out/sampleT got %0d/%0d expected %0d/%0d",
                 i, output_data, sampleT, e.out, e.samp);
      end
      if (i - (LAT - 1) == 0 || i - (LAT - 1) == 1) begin
        n_checks++;
        if (output_data !== 32'(first[i-(LAT-1)])) begin
          n_fail++;
          $display("FAIL neg_impulse_table[%0d] got %0d expected %0d", i, output_data, first[i-(LAT-1)]);
        end
      end
    end
  endtask

  task automatic test_enable_gating();
    exp_t               e;
    logic signed [31:0] held_out;
    logic signed [15:0] held_samp;
    do_reset();
    held_out  = '0;
    held_samp = '0;
    for (int i = 0; i < 13; i++) begin
      if (i >= 3 && i < 6) apply(1'b0, 1'b0, 16'($urandom));
      else                 apply(1'b0, 1'b1, (i == 0) ? 16'sd1 : 16'sd0);
      e = sb.pop_front();
      n_checks++;
      if (output_data !== e.out || sampleT !== e.samp) begin
        n_fail++;
        $display("FAIL gating[%0d] out/sampleT got %0d/%0d expected %0d/%0d",
                 i, output_data, sampleT, e.out, e.samp);
      end
      if (i >= 3 && i < 6) begin
        n_checks++;
        if (output_data !== held_out || sampleT !== held_samp) begin
          n_fail++;
          $display("FAIL gating_hold[%0d] out/sampleT got %0d/%0d expected %0d/%0d",
                   i, output_data, sampleT, held_out, held_samp);
        end
      end else begin
        held_out  = output_data;
        held_samp = sampleT;
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      apply((i == 4) ? 1'b1 : 1'b0, 1'b1, 16'sd500);
      e = sb.pop_front();
      n_checks++;
      if (output_data !== e.out || sampleT !== e.samp) begin
        n_fail++;
        $display("FAIL mid_reset[%0d] out/sampleT got %0d/%0d expected %0d/%0d",
                 i, output_data, sampleT, e.out, e.samp);
      end
      if (i == 4) begin
        n_checks++;
        if (output_data !== 32'sd0 || sampleT !== 16'sd0) begin
          n_fail++;
          $display("FAIL mid_reset_clear out/sampleT got %0d/%0d expected 0/0", output_data, sampleT);
        end
      end
      if (i == 4 + LAT) begin
        n_checks++;
        if (output_data !== -32'sd1000) begin
          n_fail++;
          $display("FAIL mid_reset_restart got %0d expected -1000", output_data);
        end
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      apply(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 7), 16'($urandom));
      e = sb.pop_front();
      n_checks++;
      if (output_data !== e.out || sampleT !== e.samp) begin
        n_fail++;
        $display("FAIL random[%0d] out/sampleT got %0d/%0d expected %0d/%0d",
                 i, output_data, sampleT, e.out, e.samp);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) m_hist[k] = 0;
    test_reset();
    test_impulse();
    test_step();
    test_neg_impulse();
    test_enable_gating();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
